mc_control_fsm: RTL

- Multicycle control FSM for the RV32I core.
- Sequences fetch, decode, execute, memory and writeback.
- Drives the program counter's PCWrite / PCWriteCond / PCSource controls, plus the IR, register-file, ALU-mux and memory handshake controls.
- Sits between the instruction register / decoder and the datapath. It is the only source of PC update enables.

---
 rtl/mc_control_fsm.sv | 118 +++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle control FSM for the RV32I core (fetch/decode/execute/memory/writeback)
//   clk, rst          : clock, synchronous active-high reset
//   opcode[6:0]       : IR opcode field, stable from DECODE onward
//   mem_ready         : memory completes the current request this cycle
//   mem_req, mem_we   : memory request (held until mem_ready) and store/read select
//   ir_write          : latch fetched word into IR (FETCH, qualified by mem_ready)
//   pc_write, pc_write_cond, pc_source[1:0] : PC update controls
//   reg_write, wb_sel[1:0]                  : register-file write enable and source
//   alu_src_a/b[1:0], alu_op[1:0]           : ALU operand muxes and operation class
//   mem_timeout       : sticky flag, memory wait reached MEM_TIMEOUT (0 disables)
//   state[3:0]        : current state encoding, for debug
// Build option: define ILLEGAL_TRAP_EN to trap unrecognised opcodes (otherwise they act as NOPs).
module mc_control_fsm #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       mem_timeout,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3, EXEC_U = 4'd4,
    ADDR = 4'd5, MEM_RD = 4'd6, MEM_WR = 4'd7, WB_ALU = 4'd8, WB_MEM = 4'd9,
    BRANCH = 4'd10, JAL = 4'd11, JALR = 4'd12, TRAP = 4'd13
  } state_t;

  localparam logic [7:0] LIM = 8'(MEM_TIMEOUT);

  state_t     cur, nxt, ill;
  logic [7:0] cnt, cnt_nxt;
  logic       pw_r;

`ifdef ILLEGAL_TRAP_EN
  assign ill = TRAP;
`else
  assign ill = FETCH;
`endif

  always_comb begin
    nxt = cur;
    case (cur)
      FETCH:  nxt = mem_ready ? DECODE : FETCH;
      DECODE:
        case (opcode)
          7'b0110011:             nxt = EXEC_R;
          7'b0010011:             nxt = EXEC_I;
          7'b0110111, 7'b0010111: nxt = EXEC_U;
          7'b0000011, 7'b0100011: nxt = ADDR;
          7'b1100011:             nxt = BRANCH;
          7'b1101111:             nxt = JAL;
          7'b1100111:             nxt = JALR;
          default:                nxt = ill;
        endcase
      EXEC_R, EXEC_I, EXEC_U: nxt = WB_ALU;
      ADDR:   nxt = opcode[5] ? MEM_WR : MEM_RD;
      MEM_RD: nxt = mem_ready ? WB_MEM : MEM_RD;
      MEM_WR: nxt = mem_ready ? FETCH : MEM_WR;
      TRAP:   nxt = TRAP;
      default: nxt = FETCH;
    endcase
  end

  // Wait counter saturates at 255 so a stuck memory cannot wrap it back below the limit.
  assign cnt_nxt = mem_ready ? 8'd0 : (mem_req && cnt != 8'hff) ? cnt + 8'd1 : cnt;

  // Moore outputs are decoded from the next state and registered, so they are glitch-free
  // and valid for the whole cycle the FSM spends in that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur           <= FETCH;
      cnt           <= 8'd0;
      mem_timeout   <= 1'b0;
      mem_req       <= 1'b1;
      mem_we        <= 1'b0;
      pw_r          <= 1'b0;
      pc_write_cond <= 1'b0;
      pc_source     <= 2'b00;
      reg_write     <= 1'b0;
      wb_sel        <= 2'b00;
      alu_src_a     <= 2'b00;
      alu_src_b     <= 2'b00;
      alu_op        <= 2'b00;
    end else begin
      cur           <= nxt;
      cnt           <= cnt_nxt;
      mem_timeout   <= mem_timeout | (LIM != 8'd0 && cnt_nxt >= LIM);
      mem_req       <= nxt inside {FETCH, MEM_RD, MEM_WR};
      mem_we        <= nxt == MEM_WR;
      pw_r          <= nxt inside {JAL, JALR};
      pc_write_cond <= nxt == BRANCH;
      pc_source     <= nxt == BRANCH ? 2'b01 : nxt == JAL ? 2'b10 : nxt == JALR ? 2'b11 : 2'b00;
      reg_write     <= nxt inside {WB_ALU, WB_MEM, JAL, JALR};
      wb_sel        <= nxt == WB_MEM ? 2'b01 : nxt inside {JAL, JALR} ? 2'b10 : 2'b00;
      alu_src_a     <= nxt inside {EXEC_R, EXEC_I, ADDR, BRANCH} ? 2'b01 :
                       (nxt == EXEC_U && opcode[5]) ? 2'b10 : 2'b00;
      alu_src_b     <= nxt inside {DECODE, EXEC_I, EXEC_U, ADDR} ? 2'b01 : 2'b00;
      alu_op        <= nxt inside {EXEC_R, EXEC_I} ? 2'b10 : nxt == BRANCH ? 2'b01 : 2'b00;
    end
  end

  // FETCH strobes must fire in the same cycle memory returns data, so they bypass the register.
  assign ir_write = cur == FETCH && mem_ready;
  assign pc_write = pw_r | ir_write;
  assign state    = cur;
endmodule
